// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, default constants and PC legality helper for
//               the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states: waiting on memory, presenting a good
    // instruction, presenting an address-error nop.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        BAD   = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_PC   = 32'h0000_4180;
    localparam int          DEFAULT_IM_WORDS = 4096;

    // A PC is fetchable when word aligned and inside the instruction memory
    // window starting at base.
    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input int          words);
        logic [31:0] last;
        last = base + (32'(words) * 32'd4) - 32'd4;
        return (pc[1:0] == 2'b00) && (pc >= base) && (pc <= last);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect
// Description : Pending-redirect bookkeeping for the fetch sequencer. Holds
//               the delayed-slot branch target and the discard flag for an
//               outstanding request, resolves exc > eret > branch priority,
//               and presents the PC to load in place of pc+4.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_PC = DEFAULT_EXC_PC
) (
    input  logic         clk,
    input  logic         reset,
    input  fetch_state_t state,
    input  logic         im_ack,
    input  logic         pc_load,
    input  logic         br_valid,
    input  logic [31:0]  br_target,
    input  logic         exc_valid,
    input  logic         eret_valid,
    input  logic [31:0]  epc,
    output logic         flush_req,
    output logic         flush,
    output logic         redir_vld,
    output logic [31:0]  redir_pc
);

    logic        r_pend_vld;
    logic [31:0] r_pend_pc;
    logic        r_flush;
    logic [31:0] w_flush_tgt;
    logic        w_fetch_busy;

    // Priority resolution: an exception/eret this cycle wins, then a
    // discard already in flight, then a branch arriving this cycle (it
    // bypasses the register so the delay slot leaving now is followed by the
    // target), then a branch recorded earlier.
    always_comb begin
        flush_req    = exc_valid | eret_valid;
        w_flush_tgt  = exc_valid ? EXC_PC : epc;
        w_fetch_busy = (state == FETCH) && !im_ack;
        redir_vld    = 1'b1;
        redir_pc     = w_flush_tgt;
        if (!flush_req) begin
            if (r_flush) begin
                redir_pc = r_pend_pc;
            end else if (br_valid) begin
                redir_pc = br_target;
            end else begin
                redir_vld = r_pend_vld;
                redir_pc  = r_pend_pc;
            end
        end
    end

    assign flush = r_flush;

    // Pending state: cleared whenever the PC is reloaded; a flush during an
    // outstanding request parks its target here; branches are ignored while
    // a discard is pending because the flush already owns the next PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_vld <= 1'b0;
            r_pend_pc  <= 32'd0;
            r_flush    <= 1'b0;
        end else if (pc_load) begin
            r_pend_vld <= 1'b0;
            r_flush    <= 1'b0;
        end else if (w_fetch_busy && flush_req) begin
            r_flush    <= 1'b1;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= w_flush_tgt;
        end else if (br_valid && !r_flush) begin
            r_pend_vld <= 1'b1;
            r_pend_pc  <= br_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch sequencer. Holds the fetch PC, runs the req/ack
//               handshake to a multi-cycle instruction memory and presents
//               one instruction at a time to the F/D register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEFAULT_EXC_PC,
    parameter int          IM_WORDS = DEFAULT_IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_adel
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_instr_q;
    logic [31:0]  w_instr_nxt;
    logic         w_pc_load;
    logic [31:0]  w_load_pc;
    logic         w_flush_req;
    logic         w_flush;
    logic         w_redir_vld;
    logic [31:0]  w_redir_pc;

    fetch_redirect #(
        .EXC_PC (EXC_PC)
    ) u_redirect (
        .clk        (clk),
        .reset      (reset),
        .state      (r_state),
        .im_ack     (im_ack),
        .pc_load    (w_pc_load),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .epc        (epc),
        .flush_req  (w_flush_req),
        .flush      (w_flush),
        .redir_vld  (w_redir_vld),
        .redir_pc   (w_redir_pc)
    );

    // Next PC whenever one is loaded; the increment wraps modulo 2^32.
    assign w_load_pc = w_redir_vld ? w_redir_pc : (r_pc + 32'd4);

    // Next-state logic; every PC load re-checks legality so an illegal PC
    // never issues a request and lands directly in BAD.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr_q;
        w_pc_load   = 1'b0;
        case (r_state)
            FETCH: begin
                if (im_ack) begin
                    if (w_flush_req || w_flush) begin
                        w_pc_load = 1'b1;
                    end else begin
                        w_instr_nxt = im_rdata;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD, BAD: begin
                if (w_flush_req || !stall) begin
                    w_pc_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
        if (w_pc_load) begin
            w_pc_nxt    = w_load_pc;
            w_state_nxt = pc_legal(w_load_pc, RESET_PC, IM_WORDS) ? FETCH : BAD;
        end
    end

    // State, PC and captured instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_instr_q <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr_q <= w_instr_nxt;
        end
    end

    // Request is gated during reset so an abandoned transaction drops cleanly.
    assign im_req  = (r_state == FETCH) && !reset;
    assign im_addr = r_pc;
    assign f_valid = (r_state == HOLD) || (r_state == BAD);
    assign f_pc    = r_pc;
    assign f_instr = (r_state == HOLD) ? r_instr_q : 32'd0;
    assign f_adel  = (r_state == BAD);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl: directed scenarios plus
//               randomized traffic against a behavioural fetch model and a
//               variable-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] C_LAST_PC  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        exc_valid = 1'b0;
    logic        eret_valid = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = 32'd0;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_adel;

    int checks = 0;
    int errors = 0;

    // Memory model state and per-cycle samples
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    int          wait_cfg = 0;
    logic        s_req = 1'b0;
    logic        s_ack = 1'b0;
    logic [31:0] s_rdata = 32'd0;

    // Behavioural fetch model
    bit          m_pres = 1'b0;
    bit          m_bad = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pend_q[$];
    bit          m_drop = 1'b0;
    logic [31:0] m_drop_pc = 32'd0;

    fetch_ctrl #(
        .RESET_PC (C_RESET_PC),
        .EXC_PC   (C_EXC_PC),
        .IM_WORDS (4096)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .epc        (epc),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .f_valid    (f_valid),
        .f_pc       (f_pc),
        .f_instr    (f_instr),
        .f_adel     (f_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= C_RESET_PC) && (a <= C_LAST_PC);
    endfunction

    // Jump the model to a new PC: any pending redirect is consumed.
    function automatic void m_goto(input logic [31:0] a);
        m_pc   = a;
        m_pend_q.delete();
        m_drop = 1'b0;
        m_bad  = !legal(a);
        m_pres = m_bad;
    endfunction

    function automatic void m_set_branch(input logic [31:0] t);
        m_pend_q.delete();
        m_pend_q.push_back(t);
    endfunction

    // One clock of the fetch rules applied to this cycle's inputs.
    function automatic void model_update();
        logic        fl;
        logic [31:0] ftgt;
        fl   = exc_valid || eret_valid;
        ftgt = exc_valid ? C_EXC_PC : epc;
        if (reset) begin
            m_pc = C_RESET_PC; m_pres = 1'b0; m_bad = 1'b0;
            m_instr = 32'd0; m_pend_q.delete(); m_drop = 1'b0;
        end else if (!m_pres) begin
            if (s_ack) begin
                if (fl) m_goto(ftgt);
                else if (m_drop) m_goto(m_drop_pc);
                else begin
                    m_instr = s_rdata; m_pres = 1'b1; m_bad = 1'b0;
                    if (br_valid) m_set_branch(br_target);
                end
            end else if (fl) begin
                m_drop = 1'b1; m_drop_pc = ftgt; m_pend_q.delete();
            end else if (br_valid && !m_drop) begin
                m_set_branch(br_target);
            end
        end else begin
            if (fl) m_goto(ftgt);
            else if (!stall) begin
                if (br_valid) m_goto(br_target);
                else if (m_pend_q.size() != 0) m_goto(m_pend_q[0]);
                else m_goto(m_pc + 32'd4);
            end else if (br_valid) begin
                m_set_branch(br_target);
            end
        end
    endfunction

    // Let the DUT settle, answer its request, and sample the handshake.
    task automatic settle();
        #1;
        if (im_req && !mem_busy) begin
            mem_busy = 1'b1;
            mem_cnt  = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        end
        im_ack   = im_req && mem_busy && (mem_cnt == 0);
        im_rdata = rom(im_addr);
        #1;
        s_req = im_req; s_ack = im_ack; s_rdata = im_rdata;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        if (s_req && s_ack) mem_busy = 1'b0;
        else if (s_req) mem_cnt--;
        else mem_busy = 1'b0;
        @(negedge clk);
        br_valid = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0;
        settle(); advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        wait_cfg = 0;
        reset = 1'b1; settle();
        checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL reset_req_gated got %b exp 0", im_req); end
        advance();
        reset = 1'b0; settle();
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got %b exp 0", f_valid); end
        checks++; if (f_pc !== C_RESET_PC) begin errors++; $display("FAIL reset_f_pc got %h exp %h", f_pc, C_RESET_PC); end
        checks++; if (f_instr !== 32'd0) begin errors++; $display("FAIL reset_f_instr got %h exp 0", f_instr); end
        checks++; if (f_adel !== 1'b0) begin errors++; $display("FAIL reset_f_adel got %b exp 0", f_adel); end
        checks++; if (im_req !== 1'b1 || im_addr !== C_RESET_PC) begin errors++; $display("FAIL reset_first_req got %b/%h exp 1/%h", im_req, im_addr, C_RESET_PC); end
        advance();
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        wait_cfg = 0; do_reset();
        for (int i = 0; i < 6; i++) begin
            a = C_RESET_PC + 32'(4 * (i / 2));
            settle();
            if (i % 2 == 0) begin
                checks++; if (im_req !== 1'b1 || im_addr !== a || f_valid !== 1'b0) begin errors++; $display("FAIL zw_req cyc %0d got req=%b addr=%h fv=%b exp 1 %h 0", i, im_req, im_addr, f_valid, a); end
            end else begin
                checks++; if (f_valid !== 1'b1 || f_pc !== a || f_instr !== rom(a) || im_req !== 1'b0) begin errors++; $display("FAIL zw_present cyc %0d got fv=%b pc=%h ins=%h req=%b exp 1 %h %h 0", i, f_valid, f_pc, f_instr, im_req, a, rom(a)); end
            end
            advance();
        end
    endtask

    task automatic test_wait_stall();
        wait_cfg = 3; do_reset();
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (im_req !== 1'b1 || im_addr !== C_RESET_PC || f_valid !== 1'b0) begin errors++; $display("FAIL ws_wait cyc %0d got req=%b addr=%h fv=%b", i, im_req, im_addr, f_valid); end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            stall = 1'b1; settle();
            checks++; if (f_valid !== 1'b1 || f_pc !== C_RESET_PC || f_instr !== rom(C_RESET_PC) || im_req !== 1'b0) begin errors++; $display("FAIL ws_stall cyc %0d got fv=%b pc=%h ins=%h req=%b", i, f_valid, f_pc, f_instr, im_req); end
            advance();
        end
        stall = 1'b0; settle();
        checks++; if (f_valid !== 1'b1 || im_req !== 1'b0) begin errors++; $display("FAIL ws_release got fv=%b req=%b exp 1 0", f_valid, im_req); end
        advance(); settle();
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h3004) begin errors++; $display("FAIL ws_next_req got %b/%h exp 1/00003004", im_req, im_addr); end
        advance();
    endtask

    task automatic test_branch();
        wait_cfg = 0; do_reset();
        for (int i = 0; i < 5; i++) begin settle(); advance(); end
        stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100; settle();
        checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3008) begin errors++; $display("FAIL br_slot got fv=%b pc=%h exp 1 00003008", f_valid, f_pc); end
        advance();
        stall = 1'b0; settle();
        checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3008) begin errors++; $display("FAIL br_slot_kept got fv=%b pc=%h exp 1 00003008", f_valid, f_pc); end
        advance(); settle();
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h3100) begin errors++; $display("FAIL br_target got %b/%h exp 1/00003100", im_req, im_addr); end
        advance();
    endtask

    task automatic test_exc_outstanding();
        wait_cfg = 0; do_reset();
        for (int i = 0; i < 5; i++) begin settle(); advance(); end
        wait_cfg = 2; settle(); advance();
        exc_valid = 1'b1; settle();
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h300C || f_valid !== 1'b0) begin errors++; $display("FAIL exc_req got %b/%h fv=%b exp 1/0000300c 0", im_req, im_addr, f_valid); end
        advance(); settle();
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h300C || f_valid !== 1'b0) begin errors++; $display("FAIL exc_req_held got %b/%h fv=%b", im_req, im_addr, f_valid); end
        advance(); settle();
        checks++; if (f_valid !== 1'b0 || im_ack !== 1'b1) begin errors++; $display("FAIL exc_ack_cycle got fv=%b ack=%b exp 0 1", f_valid, im_ack); end
        advance(); wait_cfg = 0; settle();
        checks++; if (im_req !== 1'b1 || im_addr !== C_EXC_PC || f_valid !== 1'b0) begin errors++; $display("FAIL exc_redirect got %b/%h fv=%b exp 1/%h 0", im_req, im_addr, f_valid, C_EXC_PC); end
        advance(); settle();
        checks++; if (f_valid !== 1'b1 || f_pc !== C_EXC_PC || f_instr !== rom(C_EXC_PC)) begin errors++; $display("FAIL exc_present got fv=%b pc=%h ins=%h", f_valid, f_pc, f_instr); end
        advance();
    endtask

    task automatic test_exc_br_eret();
        wait_cfg = 0; do_reset();
        settle(); advance();
        exc_valid = 1'b1; br_valid = 1'b1; br_target = 32'h3200; settle(); advance();
        settle();
        checks++; if (im_req !== 1'b1 || im_addr !== C_EXC_PC || f_valid !== 1'b0) begin errors++; $display("FAIL excbr_req got %b/%h fv=%b", im_req, im_addr, f_valid); end
        advance(); settle();
        checks++; if (f_valid !== 1'b1 || f_pc !== C_EXC_PC) begin errors++; $display("FAIL excbr_present got fv=%b pc=%h", f_valid, f_pc); end
        advance(); settle();
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h4184) begin errors++; $display("FAIL excbr_dropped got %b/%h exp 1/00004184", im_req, im_addr); end
        advance(); settle();
        eret_valid = 1'b1; epc = 32'h3002; settle(); advance(); settle();
        checks++; if (f_valid !== 1'b1 || f_adel !== 1'b1 || f_instr !== 32'd0 || f_pc !== 32'h3002 || im_req !== 1'b0) begin errors++; $display("FAIL eret_bad got fv=%b adel=%b ins=%h pc=%h req=%b", f_valid, f_adel, f_instr, f_pc, im_req); end
        advance();
    endtask

    task automatic test_range_end();
        wait_cfg = 0; do_reset();
        settle(); advance();
        stall = 1'b1; br_valid = 1'b1; br_target = C_LAST_PC; settle(); advance();
        stall = 1'b0; settle();
        checks++; if (f_valid !== 1'b1 || f_pc !== C_RESET_PC) begin errors++; $display("FAIL end_slot got fv=%b pc=%h", f_valid, f_pc); end
        advance(); settle();
        checks++; if (im_req !== 1'b1 || im_addr !== C_LAST_PC) begin errors++; $display("FAIL end_req got %b/%h exp 1/%h", im_req, im_addr, C_LAST_PC); end
        advance(); settle();
        checks++; if (f_valid !== 1'b1 || f_adel !== 1'b0 || f_pc !== C_LAST_PC || f_instr !== rom(C_LAST_PC)) begin errors++; $display("FAIL end_last_ok got fv=%b adel=%b pc=%h ins=%h", f_valid, f_adel, f_pc, f_instr); end
        advance(); settle();
        checks++; if (f_valid !== 1'b1 || f_adel !== 1'b1 || f_pc !== 32'h7000 || f_instr !== 32'd0 || im_req !== 1'b0) begin errors++; $display("FAIL end_over got fv=%b adel=%b pc=%h ins=%h req=%b", f_valid, f_adel, f_pc, f_instr, im_req); end
        advance();
    endtask

    task automatic test_reset_mid();
        wait_cfg = 3; do_reset();
        settle();
        checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", im_req); end
        advance();
        reset = 1'b1; settle();
        checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL rmid_gated got %b exp 0", im_req); end
        advance();
        reset = 1'b0; settle();
        checks++; if (im_req !== 1'b1 || im_addr !== C_RESET_PC || f_valid !== 1'b0) begin errors++; $display("FAIL rmid_restart got %b/%h fv=%b", im_req, im_addr, f_valid); end
        advance();
    endtask

    function automatic logic [31:0] rnd_target();
        case ($urandom_range(0, 9))
            0: return C_RESET_PC + 32'(4 * $urandom_range(0, 4095)) + 32'($urandom_range(1, 3));
            1: return $urandom_range(0, 1) ? C_LAST_PC : C_LAST_PC - 32'd4;
            2: return $urandom_range(0, 1) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            default: return C_RESET_PC + 32'(4 * $urandom_range(0, 4095));
        endcase
    endfunction

    task automatic test_random();
        wait_cfg = -1; do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            stall      = ($urandom_range(0, 9) < 3);
            br_valid   = ($urandom_range(0, 15) == 0);
            br_target  = rnd_target();
            exc_valid  = ($urandom_range(0, 39) == 0);
            eret_valid = ($urandom_range(0, 39) == 0);
            epc        = rnd_target();
            settle();
            checks++; if (im_req !== (!m_pres && !reset)) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", i, im_req, !m_pres && !reset); end
            if (!m_pres && !reset) begin
                checks++; if (im_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, im_addr, m_pc); end
            end
            checks++; if (f_valid !== m_pres || f_adel !== (m_pres && m_bad)) begin errors++; $display("FAIL rnd_flags cyc %0d got fv=%b adel=%b exp %b %b", i, f_valid, f_adel, m_pres, m_pres && m_bad); end
            if (m_pres) begin
                checks++; if (f_pc !== m_pc || f_instr !== (m_bad ? 32'd0 : m_instr)) begin errors++; $display("FAIL rnd_present cyc %0d got pc=%h ins=%h exp %h %h", i, f_pc, f_instr, m_pc, m_bad ? 32'd0 : m_instr); end
            end
            advance();
        end
        reset = 1'b0; stall = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_stall();
        test_branch();
        test_exc_outstanding();
        test_exc_br_eret();
        test_range_end();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the next-PC logic and a multi-cycle instruction memory. Holds the fetch PC and runs a req/ack handshake to the memory. Handles stalls from decode, delayed-slot branch redirects, exception/eret flushes and PC address errors. Presents one instruction at a time to the F/D register with a valid flag.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_PC, 32'h0000_4180, exception handler entry.
- IM_WORDS, 4096, instruction memory depth. The legal PC range is RESET_PC .. RESET_PC+4*IM_WORDS-4.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- stall, in, 1: decode cannot accept; hold the presented instruction.
- br_valid, in, 1: one-cycle pulse, taken branch/jump resolved in D.
- br_target, in, 32: branch target, sampled when br_valid=1.
- exc_valid, in, 1: one-cycle pulse, exception; flush and go to EXC_PC.
- eret_valid, in, 1: one-cycle pulse, eret; flush and go to epc.
- epc, in, 32: return address, sampled when eret_valid=1.
- im_req, out, 1: memory request.
- im_addr, out, 32: word address for the request.
- im_ack, in, 1: request accepted and data valid this cycle. May be high in the same cycle as im_req.
- im_rdata, in, 32: instruction word, valid when im_ack=1.
- f_valid, out, 1: f_instr/f_pc are valid for decode.
- f_pc, out, 32: PC of the presented instruction.
- f_instr, out, 32: presented instruction.
- f_adel, out, 1: presented PC is misaligned or out of range.

## Operation
- Registers:
  - pc: the fetch PC.
  - state: one of FETCH, HOLD, BAD.
  - pend_vld / pend_pc: pending redirect.
  - flush: discard flag for the outstanding request.
  - instr_q: captured instruction.
- FETCH:
  - Drive im_req=1 and im_addr=pc. Both stay stable until im_ack.
  - On im_ack with flush=0: capture instr_q=im_rdata and go to HOLD.
  - On im_ack with flush=1: discard data, load pc=pend_pc, clear pend_vld and flush, stay in FETCH.
- Address check, done on pc entering FETCH:
  - If pc[1:0]!=0 or pc is outside the legal range, issue no request and go straight to BAD.
- HOLD: f_valid=1, f_instr=instr_q, f_pc=pc, f_adel=0.
- BAD: f_valid=1, f_instr=0 (nop), f_pc=pc, f_adel=1.
- Advance from HOLD/BAD when stall=0:
  - pc = pend_vld ? pend_pc : pc+4.
  - Clear pend_vld and go to FETCH. The address check applies on entry.
- Branch (delay slot):
  - br_valid sets pend_vld=1 and pend_pc=br_target in any state.
  - The presented/outstanding instruction is kept; it is the delay slot.
  - A second br_valid before consumption overwrites pend_pc.
- Exception/eret flush:
  - Priority is exc_valid > eret_valid > br_valid in the same cycle. The flush target is EXC_PC or epc.
  - In HOLD/BAD: next cycle pc=target, state FETCH, f_valid=0. Any pending branch is dropped.
  - In FETCH with im_ack=0 (request outstanding): set flush=1 and pend_pc=target. The request is not cancelled. f_valid stays 0.
  - In FETCH with im_ack=1: discard data and go directly to FETCH at the target.
- stall has no effect in FETCH.
- f_valid=0 in FETCH; f_pc=pc and f_instr=instr_q are don't-care there.

## Timing
- Reset (cycle after the reset edge):
  - state=FETCH, pc=RESET_PC.
  - pend_vld=0, flush=0, instr_q=0.
  - f_valid=0, f_pc=RESET_PC, f_instr=0, f_adel=0.
- im_req is gated to 0 while reset=1. im_ack in that cycle is ignored.
- Reset mid-request abandons the transaction. The memory tolerates a dropped im_req.
- Zero-wait memory: im_req in cycle N, im_ack in N, f_valid in N+1. Peak throughput is 1 instruction per 2 cycles.
- With k wait cycles, f_valid rises in N+k+1.
- After a flush from HOLD: im_req at the target in the next cycle.
- pc+4 wraps modulo 2^32. The wrapped value fails the range check and goes to BAD.

## Structure
- Package fetch_pkg holds:
  - the state enum {FETCH, HOLD, BAD};
  - the default constants RESET_PC, EXC_PC, IM_WORDS;
  - a function pc_legal(pc).
- One sub-module, fetch_redirect, holds pend_vld/pend_pc/flush. It does the priority resolution and exposes the next-pc select.

## Test plan
- Reset, then zero-wait memory with stall=0 → im_addr 0x3000, 0x3004, 0x3008 on alternate cycles; f_valid high every second cycle.
- Memory with 3 wait cycles; stall=1 for 4 cycles in HOLD → im_addr held stable; f_instr/f_pc held; no new im_req until stall=0.
- br_valid with target 0x3100 while presenting 0x3008 → 0x3008 (delay slot) is consumed, then im_addr=0x3100.
- exc_valid while a request to 0x300C is outstanding (ack delayed 2 cycles) → data discarded; f_valid stays 0; next im_addr=0x4180.
- exc_valid and br_valid in the same cycle → pc=0x4180 and the branch is dropped. eret_valid with epc=0x3002 → BAD: f_adel=1, f_instr=0, f_pc=0x3002, no im_req.
- Jump to 0x6FFC, then advance → 0x6FFC fetched normally; 0x7000 gives f_adel=1. Reset asserted mid-wait → im_req=0 during reset, then restart at 0x3000.
